// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//
// Shares one ripple-carry adder between R requesters. A round-robin
// arbiter picks one valid requester whenever the one-entry result slot is
// free (empty, or being consumed this cycle). The chosen operand pair is
// added in the grant cycle. The (N+1)-bit sum and the requester index are
// captured in the result register at that edge.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both 1. A producer holds valid and its data
// stable until that edge. Ready may depend combinationally on the other
// side's inputs.
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   req_valid  in  R      requester i has an operand pair
//   req_a      in  R*N    requester i's A operand at [i*N +: N]
//   req_b      in  R*N    requester i's B operand at [i*N +: N]
//   req_ready  out R      one-hot grant (or all zeros)
//   res_valid  out 1      result register holds an unconsumed sum
//   res_data   out N+1    {carry, sum}
//   res_id     out ID_W   index of the requester that produced res_data
//   res_ready  in  1      consumer accepts the result

module NBitRippleCarryAdder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   total
);
    logic carry;

    // Carry is a running variable, so the chain is one ordered loop.
    always_comb begin
        total = '0;
        carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            total[i] = a[i] ^ b[i] ^ carry;
            carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        total[N] = carry;
    end
endmodule

module adder_share_arbiter #(
    parameter  int N    = 4,
    parameter  int R    = 4,
    localparam int ID_W = $clog2(R)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [R-1:0]      req_valid,
    input  logic [R*N-1:0]    req_a,
    input  logic [R*N-1:0]    req_b,
    output logic [R-1:0]      req_ready,
    output logic              res_valid,
    output logic [N:0]        res_data,
    output logic [ID_W-1:0]   res_id,
    input  logic              res_ready
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;

    logic              slot_free;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [N-1:0]      a_arr [R];
    logic [N-1:0]      b_arr [R];
    logic [N:0]        sum;

    for (genvar g = 0; g < R; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*N +: N];
        assign b_arr[g] = req_b[g*N +: N];
    end

    // Round-robin search starting just after the last granted index.
    // rst_n gates the grant so nothing is acknowledged while in reset.
    always_comb begin
        slot_free = (state == EMPTY) || res_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= R; k++) begin
            cand = ID_W'((int'(last_grant) + k) % R);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant_any = grant_any && slot_free && rst_n;
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    NBitRippleCarryAdder #(.N(N)) u_adder (
        .a     (a_arr[grant_idx]),
        .b     (b_arr[grant_idx]),
        .total (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            res_data   <= '0;
            res_id     <= '0;
            last_grant <= ID_W'(R - 1);
        end else if (grant_any) begin
            // Covers both the fill from EMPTY and the back-to-back
            // consume-and-refill from FULL.
            state      <= FULL;
            res_data   <= sum;
            res_id     <= grant_idx;
            last_grant <= grant_idx;
        end else if (state == FULL && res_ready) begin
            // Drain: data and id keep their last values.
            state <= EMPTY;
        end
    end

    assign res_valid = (state == FULL);
endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
    localparam int N    = 4;
    localparam int R    = 4;
    localparam int ID_W = $clog2(R);
    localparam int W    = ID_W + N + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [R-1:0]      req_valid;
    logic [R*N-1:0]    req_a;
    logic [R*N-1:0]    req_b;
    logic [R-1:0]      req_ready;
    logic              res_valid;
    logic [N:0]        res_data;
    logic [ID_W-1:0]   res_id;
    logic              res_ready;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model: result slot contents and the rotation pointer.
    int           m_last;
    bit           m_full;
    logic [N:0]   m_data;
    int           m_id;
    bit           auto_drop;
    logic [W-1:0] exp_q[$];

    adder_share_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_last = R - 1;
        m_full = 1'b0;
        m_data = '0;
        m_id   = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input int a, input int b);
        req_a[i*N +: N] = N'(a);
        req_b[i*N +: N] = N'(b);
        req_valid[i]    = 1'b1;
    endtask

    // First valid requester after the last grant, or -1.
    function automatic int model_pick();
        for (int k = 1; k <= R; k++) begin
            if (req_valid[(m_last + k) % R]) return (m_last + k) % R;
        end
        return -1;
    endfunction

    function automatic logic [R-1:0] exp_grant();
        logic [R-1:0] g;
        int w;
        g = '0;
        w = model_pick();
        if (rst_n && w >= 0 && (!m_full || res_ready)) g[w] = 1'b1;
        return g;
    endfunction

    // One clock: advance the model with the inputs present at the edge.
    task automatic tick();
        int w;
        bit xfer;
        w    = model_pick();
        xfer = (w >= 0) && (!m_full || res_ready);
        @(posedge clk);
        if (xfer) begin
            m_data = (N+1)'(req_a[w*N +: N]) + (N+1)'(req_b[w*N +: N]);
            m_id   = w;
            m_last = w;
            m_full = 1'b1;
            exp_q.push_back({ID_W'(w), m_data});
        end else if (m_full && res_ready) begin
            m_full = 1'b0;
        end
        #1;
        if (xfer && auto_drop) req_valid[w] = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    // A consume happens at the next rising edge; compare what is offered.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                bad_cnt++;
                $display("FAIL sb_unexpected: got id=%0d data=%0h, expected no result", res_id, res_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({res_id, res_data} !== e) begin
                    bad_cnt++;
                    $display("FAIL sb_result: got id=%0d data=%0h expected id=%0d data=%0h",
                             res_id, res_data, e[W-1 -: ID_W], e[N:0]);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if (req_ready !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0) begin
            bad_cnt++;
            $display("FAIL reset_outputs: got ready=%b valid=%b data=%0h id=%0d expected all zero",
                     req_ready, res_valid, res_data, res_id);
        end
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        res_ready = 1'b1;
        set_req(2, 'hF, 'h1);
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0100) begin
            bad_cnt++;
            $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        tick();
        total_cnt++;
        if (res_valid !== 1'b1 || res_data !== 5'h10 || res_id !== 2'd2) begin
            bad_cnt++;
            $display("FAIL single_result: got valid=%b data=%0h id=%0d expected 1/10/2",
                     res_valid, res_data, res_id);
        end
        @(negedge clk);
        tick();
    endtask

    task automatic test_all_ready();
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        int exp_dat [5] = '{0, 2, 4, 6, 0};
        apply_reset();
        auto_drop = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < R; i++) set_req(i, i, i);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tick();
            total_cnt++;
            if (res_valid !== 1'b1 || res_id !== ID_W'(exp_ids[c]) || res_data !== (N+1)'(exp_dat[c])) begin
                bad_cnt++;
                $display("FAIL all_ready_seq%0d: got valid=%b id=%0d data=%0h expected 1/%0d/%0h",
                         c, res_valid, res_id, res_data, exp_ids[c], exp_dat[c]);
            end
        end
        req_valid = '0;
        auto_drop = 1'b1;
        @(negedge clk);
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        res_ready = 1'b0;
        set_req(0, 4, 5);
        @(negedge clk);
        tick();
        set_req(1, 2, 3);
        set_req(3, 7, 8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (req_ready !== '0 || res_valid !== 1'b1 || res_data !== 5'h09 || res_id !== 2'd0) begin
                bad_cnt++;
                $display("FAIL backpressure_hold%0d: got ready=%b valid=%b data=%0h id=%0d expected 0000/1/09/0",
                         c, req_ready, res_valid, res_data, res_id);
            end
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0010) begin
            bad_cnt++;
            $display("FAIL backpressure_release_grant: got %b expected 0010", req_ready);
        end
        tick();
        total_cnt++;
        if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 5'h05) begin
            bad_cnt++;
            $display("FAIL backpressure_next: got valid=%b id=%0d data=%0h expected 1/1/05",
                     res_valid, res_id, res_data);
        end
        @(negedge clk);
        tick();
        total_cnt++;
        if (res_id !== 2'd3 || res_data !== 5'h0F) begin
            bad_cnt++;
            $display("FAIL backpressure_after: got id=%0d data=%0h expected 3/0f", res_id, res_data);
        end
        @(negedge clk);
        tick();
    endtask

    task automatic test_rotation();
        apply_reset();
        res_ready = 1'b1;
        set_req(1, 1, 1);
        @(negedge clk);
        tick();
        set_req(0, 5, 6);
        set_req(3, 3, 4);
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b1000) begin
            bad_cnt++;
            $display("FAIL rotation_first: got %b expected 1000", req_ready);
        end
        tick();
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0001 || res_id !== 2'd3 || res_data !== 5'h07) begin
            bad_cnt++;
            $display("FAIL rotation_second: got ready=%b id=%0d data=%0h expected 0001/3/07",
                     req_ready, res_id, res_data);
        end
        tick();
        total_cnt++;
        if (res_id !== 2'd0 || res_data !== 5'h0B) begin
            bad_cnt++;
            $display("FAIL rotation_result: got id=%0d data=%0h expected 0/0b", res_id, res_data);
        end
        @(negedge clk);
        tick();
    endtask

    task automatic test_drain();
        apply_reset();
        res_ready = 1'b0;
        set_req(2, 9, 9);
        @(negedge clk);
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== '0) begin
            bad_cnt++;
            $display("FAIL drain_no_grant: got %b expected 0000", req_ready);
        end
        tick();
        total_cnt++;
        if (res_valid !== 1'b0 || res_data !== 5'h12 || res_id !== 2'd2) begin
            bad_cnt++;
            $display("FAIL drain_empty: got valid=%b data=%0h id=%0d expected 0/12/2",
                     res_valid, res_data, res_id);
        end
    endtask

    task automatic test_reset_mid_full();
        apply_reset();
        res_ready = 1'b0;
        set_req(1, 'hF, 'hF);
        @(negedge clk);
        tick();
        total_cnt++;
        if (res_valid !== 1'b1 || res_data !== 5'h1E) begin
            bad_cnt++;
            $display("FAIL midfull_setup: got valid=%b data=%0h expected 1/1e", res_valid, res_data);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        #1;
        total_cnt++;
        if (res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || req_ready !== '0) begin
            bad_cnt++;
            $display("FAIL midfull_async_reset: got valid=%b data=%0h id=%0d ready=%b expected all zero",
                     res_valid, res_data, res_id, req_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        set_req(0, 1, 2);
        set_req(2, 3, 3);
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0001) begin
            bad_cnt++;
            $display("FAIL midfull_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0100 || res_id !== 2'd0 || res_data !== 5'h03) begin
            bad_cnt++;
            $display("FAIL midfull_second: got ready=%b id=%0d data=%0h expected 0100/0/03",
                     req_ready, res_id, res_data);
        end
        tick();
        @(negedge clk);
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, (1 << N) - 1), $urandom_range(0, (1 << N) - 1));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            total_cnt++;
            if (req_ready !== exp_grant()) begin
                bad_cnt++;
                $display("FAIL random_grant@%0d: got %b expected %b", c, req_ready, exp_grant());
            end
            tick();
            total_cnt++;
            if (res_valid !== m_full || (m_full && (res_data !== m_data || res_id !== ID_W'(m_id)))) begin
                bad_cnt++;
                $display("FAIL random_result@%0d: got valid=%b data=%0h id=%0d expected %b/%0h/%0d",
                         c, res_valid, res_data, res_id, m_full, m_data, m_id);
            end
        end
        res_ready = 1'b1;
        repeat (3 * R) begin
            @(negedge clk);
            tick();
        end
        total_cnt++;
        if (exp_q.size() != 0 || res_valid !== 1'b0) begin
            bad_cnt++;
            $display("FAIL random_drain: got pending=%0d valid=%b expected 0/0", exp_q.size(), res_valid);
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        auto_drop = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_all_ready();
        test_backpressure();
        test_rotation();
        test_drain();
        test_reset_mid_full();
        test_random();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
